// File: rtl/line_xfer_sequencer.sv
// ----------------------------------------------------------------------------
// line_xfer_sequencer
//
// Moves one 4-word cache line between the cache data array and the four-bank
// main memory. A writeback streams the victim line out, word by word, with
// one word per bank. A fill streams the requested line in. The two can be
// chained: writeback first, then fill. Each request waits for its bank and
// for the global stall, and requests always go out in word order. Fill data
// comes back MEM_LAT cycles after each accepted read. An internal valid/word
// shift pipe tracks those returns so that every returning word is written
// into the cache at its own offset.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start_wb      pulse: write back the victim line
//   start_fill    pulse: fill the requested line from memory
//   index         line index, latched when a start is accepted
//   victim_tag    tag of the dirty victim, latched when a start is accepted
//   req_tag       tag of the requested line, latched when a start is accepted
//   cache_rdata   cache word at cache_offset (combinational from the array)
//   mem_busy      per-bank busy; bank number = word number
//   mem_stall     memory accepts no request this cycle
//   mem_err       memory error; aborts the transfer
//   mem_rdata     read data, valid MEM_LAT cycles after an accepted read
//   mem_wr/mem_rd single-cycle write/read request, one per word
//   mem_addr      {tag, index, word, 1'b0}
//   mem_wdata     cache_rdata while a writeback word is issued
//   cache_offset  {word, 1'b0}: word read (writeback) or written (fill)
//   cache_wr      write cache_wdata into the cache at cache_offset
//   cache_wdata   returned memory word
//   xfer_busy     high in every state except IDLE
//   xfer_done     one-cycle pulse when the line is complete
//   xfer_err      one-cycle pulse when the transfer is aborted
// ----------------------------------------------------------------------------
module line_xfer_sequencer #(
   parameter int DW       = 16,
   parameter int TAG_W    = 5,
   parameter int IDX_W    = 8,
   parameter int MEM_LAT  = 2,
   localparam int AW      = TAG_W + IDX_W + 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_wb,
   input  logic             start_fill,
   input  logic [IDX_W-1:0] index,
   input  logic [TAG_W-1:0] victim_tag,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [DW-1:0]    cache_rdata,
   input  logic [3:0]       mem_busy,
   input  logic             mem_stall,
   input  logic             mem_err,
   input  logic [DW-1:0]    mem_rdata,
   output logic             mem_wr,
   output logic             mem_rd,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic [2:0]       cache_offset,
   output logic             cache_wr,
   output logic [DW-1:0]    cache_wdata,
   output logic             xfer_busy,
   output logic             xfer_done,
   output logic             xfer_err
);

   typedef enum logic [2:0] {
      IDLE,
      WB,
      FILL,
      FWAIT,
      DONE,
      ERR
   } state_t;

   // This mask selects the last pipe stage. A word that sits in that stage
   // leaves the pipe in the current cycle.
   localparam logic [MEM_LAT-1:0] EXIT_MASK = MEM_LAT'(1) << (MEM_LAT - 1);

   state_t             state_q, state_d;
   logic [1:0]         word_q, word_d;
   logic               fill_pend_q, fill_pend_d;
   logic [IDX_W-1:0]   idx_q;
   logic [TAG_W-1:0]   vtag_q;
   logic [TAG_W-1:0]   rtag_q;
   logic               start_accept;
   logic               rd_issue;
   logic               flush;
   logic               can_issue;
   logic               pipe_exit;
   logic               pipe_drains;
   logic [MEM_LAT-1:0] pipe_v;
   logic [1:0]         pipe_w [MEM_LAT];

   // This block holds the state register, the word counter and the line
   // address. The address and tags are captured only when a start is
   // accepted, so starts that arrive mid-transfer cannot disturb them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= 2'd0;
         fill_pend_q <= 1'b0;
         idx_q       <= '0;
         vtag_q      <= '0;
         rtag_q      <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         fill_pend_q <= fill_pend_d;
         if (start_accept) begin
            idx_q  <= index;
            vtag_q <= victim_tag;
            rtag_q <= req_tag;
         end
      end
   end

   // This block is the return-tracking pipe. Every accepted read enters at
   // stage 0 with its word number. The entry reaches the last stage in the
   // same cycle that its data appears on mem_rdata. An error clears the whole
   // pipe, so words still in flight are never written into the cache.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            pipe_w[i] <= 2'd0;
         end
      end else if (flush) begin
         pipe_v <= '0;
      end else begin
         pipe_v[0] <= rd_issue;
         pipe_w[0] <= word_q;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_w[i] <= pipe_w[i-1];
         end
      end
   end

   assign can_issue   = !mem_stall && !mem_busy[word_q];
   assign pipe_exit   = pipe_v[MEM_LAT-1];
   assign pipe_drains = ((pipe_v & ~EXIT_MASK) == '0);

   // This block computes the next state and every output. Requests are
   // combinational: a word goes out in the same cycle that its bank becomes
   // free. An error takes priority over issuing, so no request leaves in the
   // cycle that mem_err is seen.
   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      fill_pend_d  = fill_pend_q;
      start_accept = 1'b0;
      rd_issue     = 1'b0;
      flush        = 1'b0;
      mem_wr       = 1'b0;
      mem_rd       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      cache_offset = 3'd0;
      cache_wr     = 1'b0;
      cache_wdata  = '0;
      xfer_busy    = (state_q != IDLE);
      xfer_done    = 1'b0;
      xfer_err     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_wb) begin
               state_d      = WB;
               fill_pend_d  = start_fill;
               word_d       = 2'd0;
               start_accept = 1'b1;
            end else if (start_fill) begin
               state_d      = FILL;
               fill_pend_d  = 1'b0;
               word_d       = 2'd0;
               start_accept = 1'b1;
            end
         end

         WB: begin
            mem_addr     = {vtag_q, idx_q, word_q, 1'b0};
            cache_offset = {word_q, 1'b0};
            if (mem_err) begin
               state_d = ERR;
               flush   = 1'b1;
            end else if (can_issue) begin
               mem_wr    = 1'b1;
               mem_wdata = cache_rdata;
               if (word_q == 2'd3) begin
                  word_d      = 2'd0;
                  fill_pend_d = 1'b0;
                  state_d     = fill_pend_q ? FILL : DONE;
               end else begin
                  word_d = word_q + 2'd1;
               end
            end
         end

         FILL: begin
            mem_addr = {rtag_q, idx_q, word_q, 1'b0};
            if (mem_err) begin
               state_d = ERR;
               flush   = 1'b1;
            end else if (can_issue) begin
               mem_rd   = 1'b1;
               rd_issue = 1'b1;
               if (word_q == 2'd3) begin
                  state_d = FWAIT;
               end else begin
                  word_d = word_q + 2'd1;
               end
            end
         end

         FWAIT: begin
            if (mem_err) begin
               state_d = ERR;
               flush   = 1'b1;
            end else if (pipe_drains) begin
               state_d = DONE;
            end
         end

         DONE: begin
            xfer_done = 1'b1;
            state_d   = IDLE;
         end

         ERR: begin
            xfer_err = 1'b1;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // The pipe is non-empty only in FILL and FWAIT. A write-back does not
      // overlap with returning fill data. If an error arrives in the same
      // cycle as a return, that returning word is dropped together with the
      // rest of the line.
      if ((state_q == FILL || state_q == FWAIT) && !mem_err && pipe_exit) begin
         cache_wr     = 1'b1;
         cache_offset = {pipe_w[MEM_LAT-1], 1'b0};
         cache_wdata  = mem_rdata;
      end
   end

endmodule

// File: tb/tb_line_xfer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_line_xfer_sequencer
//
// Directed bench for line_xfer_sequencer. Each scenario gives, cycle by
// cycle, its inputs as bit masks (stall, bank busy, error) and its expected
// request, cache-write, done and error cycles. Cycle 0 is the cycle in which
// the start pulse is presented. Addresses, write data and fill data are
// derived from the number of words seen so far: the cache array returns
// 0xC000 | offset, and the memory returns address ^ 0x5A5A after two cycles.
// ----------------------------------------------------------------------------
module tb_line_xfer_sequencer;

   localparam int DW      = 16;
   localparam int TAG_W   = 5;
   localparam int IDX_W   = 8;
   localparam int MEM_LAT = 2;
   localparam int AW      = TAG_W + IDX_W + 3;

   logic             clk;
   logic             rst;
   logic             start_wb;
   logic             start_fill;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] victim_tag;
   logic [TAG_W-1:0] req_tag;
   logic [DW-1:0]    cache_rdata;
   logic [3:0]       mem_busy;
   logic             mem_stall;
   logic             mem_err;
   logic [DW-1:0]    mem_rdata;
   logic             mem_wr;
   logic             mem_rd;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic [2:0]       cache_offset;
   logic             cache_wr;
   logic [DW-1:0]    cache_wdata;
   logic             xfer_busy;
   logic             xfer_done;
   logic             xfer_err;

   int checks = 0;
   int errors = 0;

   line_xfer_sequencer #(
      .DW(DW), .TAG_W(TAG_W), .IDX_W(IDX_W), .MEM_LAT(MEM_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start_wb(start_wb), .start_fill(start_fill),
      .index(index), .victim_tag(victim_tag), .req_tag(req_tag),
      .cache_rdata(cache_rdata), .mem_busy(mem_busy), .mem_stall(mem_stall),
      .mem_err(mem_err), .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cache_offset(cache_offset),
      .cache_wr(cache_wr), .cache_wdata(cache_wdata), .xfer_busy(xfer_busy),
      .xfer_done(xfer_done), .xfer_err(xfer_err)
   );

   // The clock period is 10 time units, with the first rising edge at t=5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // The cache array model is combinational from the offset.
   assign cache_rdata = 16'hC000 | {13'd0, cache_offset};

   // The memory model returns each read two cycles after it is accepted.
   logic [1:0]    mv;
   logic [AW-1:0] ma [2];
   always @(posedge clk) begin
      mv[0] <= mem_rd;
      mv[1] <= mv[0];
      ma[0] <= mem_addr;
      ma[1] <= ma[0];
   end
   assign mem_rdata = mv[1] ? memData(ma[1]) : 16'h0000;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Runs one scenario. It is entered 1 unit after a rising edge and returns
   // at the same phase. Checks are made 4 units after the edge.
   task automatic applyStimulus(
      input string            name,
      input logic             sw,
      input logic             sf,
      input logic [TAG_W-1:0] vt,
      input logic [TAG_W-1:0] rt,
      input logic [IDX_W-1:0] ix,
      input logic [31:0]      stall_m,
      input logic [31:0]      busy_m,
      input int               busy_bank,
      input logic [31:0]      err_m,
      input int               restart_c,
      input logic [31:0]      wr_m,
      input logic [31:0]      rd_m,
      input logic [31:0]      cwr_m,
      input int               done_c,
      input int               err_c,
      input int               ncyc);
      logic [1:0] nwr;
      logic [1:0] nrd;
      logic [1:0] ncw;
      int         last_c;
      nwr = 2'd0;
      nrd = 2'd0;
      ncw = 2'd0;
      last_c = (done_c > 0) ? done_c : err_c;
      victim_tag = vt;
      req_tag    = rt;
      index      = ix;
      for (int c = 0; c < ncyc; c++) begin
         start_wb   = (c == 0) ? sw : ((c == restart_c) ? 1'b1 : 1'b0);
         start_fill = (c == 0) ? sf : ((c == restart_c) ? 1'b1 : 1'b0);
         mem_stall  = stall_m[c];
         mem_busy   = busy_m[c] ? (4'b0001 << busy_bank) : 4'b0000;
         mem_err    = err_m[c];
         #3;
         checkOutput($sformatf("%s.c%0d.mem_wr", name, c), 32'(mem_wr), 32'(wr_m[c]));
         checkOutput($sformatf("%s.c%0d.mem_rd", name, c), 32'(mem_rd), 32'(rd_m[c]));
         checkOutput($sformatf("%s.c%0d.cache_wr", name, c), 32'(cache_wr), 32'(cwr_m[c]));
         checkOutput($sformatf("%s.c%0d.done", name, c), 32'(xfer_done),
                     32'(done_c > 0 && c == done_c));
         checkOutput($sformatf("%s.c%0d.err", name, c), 32'(xfer_err),
                     32'(err_c > 0 && c == err_c));
         checkOutput($sformatf("%s.c%0d.busy", name, c), 32'(xfer_busy),
                     32'(c >= 1 && c <= last_c));
         if (wr_m[c] && mem_wr) begin
            checkOutput($sformatf("%s.c%0d.wr_addr", name, c), 32'(mem_addr),
                        32'({vt, ix, nwr, 1'b0}));
            checkOutput($sformatf("%s.c%0d.wdata", name, c), 32'(mem_wdata),
                        32'(16'hC000 | {13'd0, nwr, 1'b0}));
            nwr = nwr + 2'd1;
         end
         if (rd_m[c] && mem_rd) begin
            checkOutput($sformatf("%s.c%0d.rd_addr", name, c), 32'(mem_addr),
                        32'({rt, ix, nrd, 1'b0}));
            nrd = nrd + 2'd1;
         end
         if (cwr_m[c] && cache_wr) begin
            checkOutput($sformatf("%s.c%0d.c_off", name, c), 32'(cache_offset),
                        32'({ncw, 1'b0}));
            checkOutput($sformatf("%s.c%0d.c_data", name, c), 32'(cache_wdata),
                        32'(memData({rt, ix, ncw, 1'b0})));
            ncw = ncw + 2'd1;
         end
         @(posedge clk);
         #1;
      end
      start_wb   = 1'b0;
      start_fill = 1'b0;
      mem_stall  = 1'b0;
      mem_busy   = 4'b0000;
      mem_err    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      start_wb   = 1'b0;
      start_fill = 1'b0;
      index      = '0;
      victim_tag = '0;
      req_tag    = '0;
      mem_busy   = 4'b0000;
      mem_stall  = 1'b0;
      mem_err    = 1'b0;
      #3;
      checkOutput("reset.busy", 32'(xfer_busy), 32'd0);
      checkOutput("reset.wr", 32'(mem_wr), 32'd0);
      checkOutput("reset.rd", 32'(mem_rd), 32'd0);
      checkOutput("reset.addr", 32'(mem_addr), 32'd0);
      checkOutput("reset.cwr", 32'(cache_wr), 32'd0);
      checkOutput("reset.done_err", 32'({xfer_done, xfer_err}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fill only, no busy or stall: reads in cycles 1-4, returns in cycles 3-6, done in cycle 7.
      applyStimulus("fill", 1'b0, 1'b1, 5'h00, 5'h03, 8'h21, 32'h0, 32'h0, 0, 32'h0, 0,
                    32'h0, 32'h1E, 32'h78, 7, 0, 9);

      // Writeback followed by fill.
      applyStimulus("wbfill", 1'b1, 1'b1, 5'h01, 5'h02, 8'h00, 32'h0, 32'h0, 0, 32'h0, 0,
                    32'h1E, 32'h1E0, 32'h780, 11, 0, 13);

      // Writeback with bank 2 busy in cycles 3-5: done moves from cycle 5 to cycle 8.
      applyStimulus("wbbusy", 1'b1, 1'b0, 5'h0A, 5'h00, 8'h5C, 32'h0, 32'h38, 2, 32'h0, 0,
                    32'hC6, 32'h0, 32'h0, 8, 0, 10);

      // Fill with a stall on word 1 in cycles 2-3, using all-ones tag and index.
      applyStimulus("fillstall", 1'b0, 1'b1, 5'h00, 5'h1F, 8'hFF, 32'h0C, 32'h0, 0, 32'h0, 0,
                    32'h0, 32'h72, 32'h1C8, 9, 0, 11);

      // Error in the first FWAIT cycle, with words 2 and 3 still outstanding.
      applyStimulus("fwaiterr", 1'b0, 1'b1, 5'h00, 5'h04, 8'h80, 32'h0, 32'h0, 0, 32'h20, 0,
                    32'h0, 32'h1E, 32'h18, 0, 6, 9);

      // A second start pulse while busy must have no effect.
      applyStimulus("restart", 1'b1, 1'b0, 5'h06, 5'h09, 8'h33, 32'h0, 32'h0, 0, 32'h0, 2,
                    32'h1E, 32'h0, 32'h0, 5, 0, 8);

      // Asynchronous reset in the middle of a writeback, between clock edges.
      victim_tag = 5'h07;
      index      = 8'h11;
      start_wb   = 1'b1;
      @(posedge clk);
      #1;
      start_wb = 1'b0;
      #3;
      checkOutput("arst.pre_wr", 32'(mem_wr), 32'd1);
      checkOutput("arst.pre_busy", 32'(xfer_busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("arst.wr", 32'(mem_wr), 32'd0);
      checkOutput("arst.busy", 32'(xfer_busy), 32'd0);
      checkOutput("arst.addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #3;
         checkOutput($sformatf("arst.after%0d.busy", c), 32'(xfer_busy), 32'd0);
         checkOutput($sformatf("arst.after%0d.done_err", c), 32'({xfer_done, xfer_err}), 32'd0);
         checkOutput($sformatf("arst.after%0d.wr", c), 32'(mem_wr), 32'd0);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
